mul_seq_unit: RTL and testbench



---
 rtl/mul_seq_unit.sv | 91 +++++++++
 tb/tb_mul_seq_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_unit.sv
// Sequential shift-add multiplier feeding the 48-bit MulFile write port.
// One iteration per clock on operand magnitudes; the sign is applied on the final write.
module mul_seq_unit #(
    parameter int WIDTH = 24
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   WriteMul,
    output logic                 RegWrite
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, WRITE} stateT;

    stateT              state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      iterCnt;
    logic               neg;

    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        magA    = (Signed && OpA[WIDTH-1]) ? ('0 - OpA) : OpA;
        magB    = (Signed && OpB[WIDTH-1]) ? ('0 - OpB) : OpB;
        accNext = mplier[0] ? (acc + mcand) : acc;
        // Sign is applied to the accumulator including the last partial product.
        product = neg ? ('0 - accNext) : accNext;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            iterCnt  <= '0;
            neg      <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            RegWrite <= 1'b0;
            WriteMul <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand   <= {{WIDTH{1'b0}}, magA};
                        mplier  <= magB;
                        neg     <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        acc     <= '0;
                        iterCnt <= '0;
                        Busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc     <= accNext;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    iterCnt <= iterCnt + 1'b1;
                    if (iterCnt == LAST_ITER) begin
                        WriteMul <= product;
                        RegWrite <= 1'b1;
                        Done     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    RegWrite <= 1'b0;
                    Done     <= 1'b0;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: cycle-level timing model plus arithmetic product reference.
module tb_mul_seq_unit;

    localparam int W = 24;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic             Signed = 1'b0;
    logic [W-1:0]     OpA = '0;
    logic [W-1:0]     OpB = '0;
    logic             Busy;
    logic             Done;
    logic [2*W-1:0]   WriteMul;
    logic             RegWrite;

    mul_seq_unit #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
        .OpA(OpA), .OpB(OpB), .Busy(Busy), .Done(Done),
        .WriteMul(WriteMul), .RegWrite(RegWrite)
    );

    always #5 Clock = ~Clock;

    int vecs = 0;
    int errs = 0;

    task automatic checkVal(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] refProd(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        return (2*W)'(x * y);
    endfunction

    // Timing model: an accepted request occupies the unit for W+1 cycles, the last one being the write.
    int             remain = 0;
    logic [2*W-1:0] pendProd = '0;
    logic [2*W-1:0] expWm = '0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            remain = 0;
            expWm  = '0;
        end else if (remain == 0) begin
            if (Start) begin
                remain   = W + 1;
                pendProd = refProd(Signed, OpA, OpB);
            end
        end else begin
            remain--;
            if (remain == 1) expWm = pendProd;
        end
    end

    bit chkEn = 1'b0;
    always @(negedge Clock) begin
        if (chkEn) begin
            checkVal("busy", Busy, remain > 0);
            checkVal("done", Done, remain == 1);
            checkVal("regWrite", RegWrite, remain == 1);
            checkVal("writeMul", WriteMul, expWm);
        end
    end

    logic [2*W-1:0] mulFile = '0;
    int rwPulses = 0;
    int cyc = 0;
    always @(posedge Clock) begin
        cyc++;
        if (RegWrite) begin
            mulFile <= WriteMul;
            rwPulses++;
        end
    end

    task automatic waitWrite(output int atCyc);
        bit ok;
        ok = 1'b0;
        atCyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (RegWrite) begin
                ok = 1'b1;
                atCyc = cyc;
                break;
            end
        end
        if (!ok) checkVal("writeTimeout", 0, 1);
    endtask

    task automatic doOp(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string tag);
        int t;
        @(negedge Clock);
        Signed = s; OpA = a; OpB = b; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        waitWrite(t);
        @(negedge Clock);
        checkVal(tag, mulFile, exp);
    endtask

    initial begin
        int t1, t2, p0;
        logic s;
        logic [W-1:0] a, b;

        repeat (2) @(negedge Clock);
        chkEn = 1'b1;
        checkVal("rstBusy", Busy, 0);
        checkVal("rstRegWrite", RegWrite, 0);
        checkVal("rstWriteMul", WriteMul, 0);
        Reset = 1'b0;

        doOp(1'b0, 24'd5, 24'd7, 48'd35, "u5x7");
        doOp(1'b1, 24'hFFFFFD, 24'd4, 48'hFFFFFFFFFFF4, "sNeg3x4");
        doOp(1'b1, 24'h800000, 24'h800000, 48'h400000000000, "sMinxMin");
        doOp(1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "uMaxxMax");
        doOp(1'b1, 24'd0, 24'hFFFFFF, 48'd0, "zeroOp");

        // Start while busy is ignored
        p0 = rwPulses;
        @(negedge Clock);
        Signed = 1'b0; OpA = 24'd5; OpB = 24'd7; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (9) @(negedge Clock);
        OpA = 24'd9; OpB = 24'd9; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        waitWrite(t1);
        @(negedge Clock);
        checkVal("ignoreWm", mulFile, 48'd35);
        repeat (3) @(negedge Clock);
        checkVal("ignorePulses", rwPulses - p0, 1);

        // Start held high: back-to-back issue
        Signed = 1'b0; OpA = 24'd11; OpB = 24'd13; Start = 1'b1;
        waitWrite(t1);
        waitWrite(t2);
        Start = 1'b0;
        checkVal("b2bInterval", t2 - t1, W + 2);
        @(negedge Clock);
        checkVal("b2bWm", mulFile, 48'd143);

        // Asynchronous reset mid-run
        @(negedge Clock);
        OpA = 24'd100; OpB = 24'd100; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (11) @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        checkVal("abortBusy", Busy, 0);
        checkVal("abortDone", Done, 0);
        checkVal("abortRegWrite", RegWrite, 0);
        checkVal("abortWriteMul", WriteMul, 0);
        @(negedge Clock);
        Reset = 1'b0;
        p0 = rwPulses;
        repeat (30) @(negedge Clock);
        checkVal("abortNoWrite", rwPulses - p0, 0);
        doOp(1'b0, 24'd2, 24'd3, 48'd6, "afterAbort");

        // Randomized operations with operands scrambled while running
        for (int n = 0; n < 25; n++) begin
            s = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            if (n % 5 == 0) a = {1'b1, {(W-1){1'b0}}};
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            Signed = s; OpA = a; OpB = b; Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge Clock);
                if (RegWrite) break;
                Signed = 1'($urandom_range(0, 1));
                OpA = W'($urandom);
                OpB = W'($urandom);
            end
            @(negedge Clock);
            checkVal("randProd", mulFile, refProd(s, a, b));
        end

        repeat (3) @(negedge Clock);
        chkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
